// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Brief    : Program-counter and run-control stage ahead of a single-cycle
//             core. Holds the architectural PC, registers the core's next
//             address on each committed instruction, traps misaligned or
//             out-of-range targets, detects the `j .` halt idiom and counts
//             retired instructions.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step_mode,
    input  logic        halt_req,
    input  logic [31:0] next_pc_in,
    output logic [31:0] pc_out,
    output logic        commit,
    output logic [1:0]  state,
    output logic [31:0] retired,
    output logic [31:0] fault_addr
);

    // Run-control states; encoding is visible on the state port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam logic [31:0] c_imem_limit  = IMEM_BYTES[31:0];
    localparam logic [31:0] c_retired_max = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_retired;
    logic [31:0] r_fault_addr;

    logic        w_aligned;
    logic        w_in_range;
    logic        w_addr_ok;
    logic        w_in_run;
    logic        w_commit;
    logic        w_trap;
    logic        w_self_loop;

    // Target legality: word aligned and inside instruction memory.
    always_comb begin
        w_aligned   = (next_pc_in[1:0] == 2'b00);
        w_in_range  = (next_pc_in < c_imem_limit);
        w_addr_ok   = w_aligned && w_in_range;
        w_in_run    = (r_state == ST_RUN);
        w_commit    = w_in_run && w_addr_ok;
        w_trap      = w_in_run && !w_addr_ok;
        w_self_loop = (next_pc_in == r_pc);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a bad target beats halt, halt beats single-step.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_addr_ok) begin
                    w_state_next = ST_FAULT;
                end else if (w_self_loop || halt_req) begin
                    w_state_next = ST_HALT;
                end else if (step_mode) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALT:  w_state_next = ST_HALT;
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // PC advances only on a committed instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_commit) begin
            r_pc <= next_pc_in;
        end
    end

    // Retired-instruction counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_commit && (r_retired != c_retired_max)) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    // Capture the offending target on the RUN->FAULT transition only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_addr <= '0;
        end else if (w_trap) begin
            r_fault_addr <= next_pc_in;
        end
    end

    assign pc_out     = r_pc;
    assign commit     = w_commit;
    assign state      = r_state;
    assign retired    = r_retired;
    assign fault_addr = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Brief    : Self-checking bench for pc_sequencer: directed vector table,
//             hand-written multi-cycle sequences and a randomized run
//             compared against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES = 1024;

    logic        clk;
    logic        rst;
    logic        start;
    logic        step_mode;
    logic        halt_req;
    logic [31:0] next_pc_in;
    logic [31:0] pc_out;
    logic        commit;
    logic [1:0]  state;
    logic [31:0] retired;
    logic [31:0] fault_addr;

    int n_pass  = 0;
    int n_total = 0;

    pc_sequencer #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step_mode  (step_mode),
        .halt_req   (halt_req),
        .next_pc_in (next_pc_in),
        .pc_out     (pc_out),
        .commit     (commit),
        .state      (state),
        .retired    (retired),
        .fault_addr (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r, s, sm, h;
        logic [31:0] npc;
        logic        ec;     // commit expected before the edge
        logic [1:0]  es;     // state after the edge
        logic [31:0] epc, eret, efa;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic s, logic sm, logic h, logic [31:0] npc,
                                logic ec, logic [1:0] es, logic [31:0] epc,
                                logic [31:0] eret, logic [31:0] efa);
        vec_t v;
        v.r = r; v.s = s; v.sm = sm; v.h = h; v.npc = npc;
        v.ec = ec; v.es = es; v.epc = epc; v.eret = eret; v.efa = efa;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Called #1 after a rising edge: drive inputs, let commit settle.
    task automatic drive(input logic r, input logic s, input logic sm, input logic h,
                         input logic [31:0] npc);
        rst = r; start = s; step_mode = sm; halt_req = h; next_pc_in = npc;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [1:0] es, input logic [31:0] epc,
                              input logic [31:0] eret, input logic [31:0] efa);
        chk({tag, ".state"},   {30'd0, state}, {30'd0, es});
        chk({tag, ".pc"},      pc_out,         epc);
        chk({tag, ".retired"}, retired,        eret);
        chk({tag, ".fault"},   fault_addr,     efa);
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_st;   // 0 idle, 1 run, 2 halt, 3 fault
    logic [31:0] m_pc, m_ret, m_fa;

    function automatic bit legal(logic [31:0] a);
        return ((a % 4) == 0) && (longint'(a) < longint'(IMEM_BYTES));
    endfunction

    function automatic bit m_commit(logic [31:0] npc);
        return (m_st == 1) && legal(npc);
    endfunction

    task automatic m_step(input logic r, input logic s, input logic sm, input logic h,
                          input logic [31:0] npc);
        if (r) begin
            m_st = 0; m_pc = RESET_PC; m_ret = 0; m_fa = 0;
        end else if (m_st == 0) begin
            if (s) m_st = 1;
        end else if (m_st == 1) begin
            if (!legal(npc)) begin
                m_st = 3;
                m_fa = npc;
            end else begin
                bit stop;
                stop = (npc == m_pc) || h;
                m_pc = npc;
                if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
                m_st = stop ? 2 : (sm ? 0 : 1);
            end
        end
    endtask

    initial begin
        int commits;
        logic [31:0] pc_h;

        // ---------------- reset state ----------------
        drive(1, 0, 0, 0, 32'h0);
        edge_wait();
        drive(0, 0, 0, 0, 32'h4);
        chk("reset.commit", {31'd0, commit}, 32'd0);
        check_regs("reset", 2'b00, RESET_PC, 32'd0, 32'd0);

        // ---------------- directed table ----------------
        // reset then run
        tv.push_back(mk(0,1,0,0, 32'h4,   0, 2'b01, 32'h0,  0, 0));
        tv.push_back(mk(0,0,0,0, 32'h4,   1, 2'b01, 32'h4,  1, 0));
        tv.push_back(mk(0,0,0,0, 32'h8,   1, 2'b01, 32'h8,  2, 0));
        tv.push_back(mk(0,0,0,0, 32'hC,   1, 2'b01, 32'hC,  3, 0));
        tv.push_back(mk(0,0,0,0, 32'h10,  1, 2'b01, 32'h10, 4, 0));
        tv.push_back(mk(0,0,0,0, 32'h10,  1, 2'b10, 32'h10, 5, 0));   // j . -> HALT
        tv.push_back(mk(0,1,0,0, 32'h14,  0, 2'b10, 32'h10, 5, 0));   // start ignored
        tv.push_back(mk(1,0,0,0, 32'h14,  0, 2'b00, 32'h0,  0, 0));
        // misaligned fault
        tv.push_back(mk(0,1,0,0, 32'h4,   0, 2'b01, 32'h0,  0, 0));
        tv.push_back(mk(0,0,0,0, 32'h4,   1, 2'b01, 32'h4,  1, 0));
        tv.push_back(mk(0,0,0,0, 32'h8,   1, 2'b01, 32'h8,  2, 0));
        tv.push_back(mk(0,0,0,0, 32'hE,   0, 2'b11, 32'h8,  2, 32'hE));
        tv.push_back(mk(0,1,0,0, 32'hC,   0, 2'b11, 32'h8,  2, 32'hE));
        tv.push_back(mk(1,0,0,0, 32'hC,   0, 2'b00, 32'h0,  0, 0));
        // range boundary
        tv.push_back(mk(0,1,0,0, 32'h3FC, 0, 2'b01, 32'h0,   0, 0));
        tv.push_back(mk(0,0,0,0, 32'h3FC, 1, 2'b01, 32'h3FC, 1, 0));
        tv.push_back(mk(0,0,0,0, 32'h400, 0, 2'b11, 32'h3FC, 1, 32'h400));
        tv.push_back(mk(1,0,0,0, 32'h0,   0, 2'b00, 32'h0,   0, 0));
        // step mode, pulses 4 cycles apart
        tv.push_back(mk(0,1,1,0, 32'h4,   0, 2'b01, 32'h0,  0, 0));
        tv.push_back(mk(0,0,1,0, 32'h4,   1, 2'b00, 32'h4,  1, 0));
        tv.push_back(mk(0,0,1,0, 32'h8,   0, 2'b00, 32'h4,  1, 0));
        tv.push_back(mk(0,0,1,0, 32'h8,   0, 2'b00, 32'h4,  1, 0));
        tv.push_back(mk(0,1,1,0, 32'h8,   0, 2'b01, 32'h4,  1, 0));
        tv.push_back(mk(0,0,1,0, 32'h8,   1, 2'b00, 32'h8,  2, 0));
        tv.push_back(mk(0,0,1,0, 32'hC,   0, 2'b00, 32'h8,  2, 0));
        tv.push_back(mk(0,0,1,0, 32'hC,   0, 2'b00, 32'h8,  2, 0));
        tv.push_back(mk(0,1,1,0, 32'hC,   0, 2'b01, 32'h8,  2, 0));
        tv.push_back(mk(0,0,1,0, 32'hC,   1, 2'b00, 32'hC,  3, 0));
        // halt_req with step_mode: HALT wins after one commit
        tv.push_back(mk(0,1,1,1, 32'h10,  0, 2'b01, 32'hC,  3, 0));
        tv.push_back(mk(0,0,1,1, 32'h10,  1, 2'b10, 32'h10, 4, 0));
        tv.push_back(mk(1,1,0,0, 32'h10,  0, 2'b00, 32'h0,  0, 0));   // reset mid-HALT
        tv.push_back(mk(0,1,0,0, 32'h4,   0, 2'b01, 32'h0,  0, 0));
        tv.push_back(mk(0,0,0,0, 32'h4,   1, 2'b01, 32'h4,  1, 0));
        // bad target with halt_req: FAULT wins, no commit
        tv.push_back(mk(0,0,0,1, 32'h6,   0, 2'b11, 32'h4,  1, 32'h6));
        tv.push_back(mk(1,0,0,0, 32'h0,   0, 2'b00, 32'h0,  0, 0));
        // self-loop with step_mode: HALT wins
        tv.push_back(mk(0,1,1,0, 32'h0,   0, 2'b01, 32'h0,  0, 0));
        tv.push_back(mk(0,0,1,0, 32'h0,   1, 2'b10, 32'h0,  1, 0));
        // reset in the middle of RUN discards the in-flight instruction
        tv.push_back(mk(1,0,0,0, 32'h0,   0, 2'b00, 32'h0,  0, 0));
        tv.push_back(mk(0,1,0,0, 32'h4,   0, 2'b01, 32'h0,  0, 0));
        tv.push_back(mk(1,0,0,0, 32'h4,   1, 2'b00, 32'h0,  0, 0));
        tv.push_back(mk(0,0,0,0, 32'h4,   0, 2'b00, 32'h0,  0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tv[i].r, tv[i].s, tv[i].sm, tv[i].h, tv[i].npc);
            chk({tag, ".commit"}, {31'd0, commit}, {31'd0, tv[i].ec});
            edge_wait();
            check_regs(tag, tv[i].es, tv[i].epc, tv[i].eret, tv[i].efa);
        end

        // ---------------- HALT holds for 10 cycles despite start ----------------
        drive(1, 0, 0, 0, 32'h0);
        edge_wait();
        drive(0, 1, 0, 0, 32'h4);
        edge_wait();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, pc_out + 32'h4);
            edge_wait();
        end
        chk("hold.pre_pc", pc_out, 32'h10);
        drive(0, 0, 0, 0, 32'h10);
        chk("hold.loop_commit", {31'd0, commit}, 32'd1);
        edge_wait();
        chk("hold.retired", retired, 32'd5);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, 32'h14);
            chk("hold.commit", {31'd0, commit}, 32'd0);
            edge_wait();
            chk("hold.pc", pc_out, 32'h10);
            chk("hold.state", {30'd0, state}, 32'd2);
        end
        chk("hold.retired_end", retired, 32'd5);

        // ---------------- step mode with start held: one commit per 2 cycles ----------------
        drive(1, 0, 0, 0, 32'h0);
        edge_wait();
        commits = 0;
        pc_h    = 32'h0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 0, pc_h + 32'h4);
            if (commit === 1'b1) begin
                commits++;
                pc_h = pc_h + 32'h4;
            end
            edge_wait();
        end
        chk("held.commits", commits, 32'd3);
        chk("held.pc", pc_out, 32'hC);
        chk("held.retired", retired, 32'd3);

        // ---------------- randomized run against the reference model ----------------
        drive(1, 0, 0, 0, 32'h0);
        m_step(1, 0, 0, 0, 32'h0);
        edge_wait();
        for (int i = 0; i < 600; i++) begin
            logic r, s, sm, h;
            logic [31:0] npc;
            int sel;
            r   = ($urandom_range(99) < ((m_st >= 2) ? 20 : 2));
            s   = ($urandom_range(1) == 1);
            sm  = ($urandom_range(3) == 0);
            h   = ($urandom_range(39) == 0);
            sel = int'($urandom_range(99));
            if (sel < 70)      npc = m_pc + 32'h4;
            else if (sel < 75) npc = m_pc;
            else if (sel < 80) npc = {$urandom_range(255), 2'b00} | 32'h1 + {31'd0, 1'($urandom_range(1))};
            else if (sel < 85) npc = IMEM_BYTES + {$urandom_range(63), 2'b00};
            else               npc = {22'd0, 8'($urandom_range(255)), 2'b00};
            drive(r, s, sm, h, npc);
            chk("rand.commit", {31'd0, commit}, {31'd0, m_commit(npc)});
            m_step(r, s, sm, h, npc);
            edge_wait();
            check_regs("rand", 2'(m_st), m_pc, m_ret, m_fa);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control stage directly upstream of the single-cycle CPU core. Holds the architectural PC, drives it as the core's instruction address, and registers the core's computed next address at each committed instruction. A run/idle/halt/fault state machine gates when instructions commit, detects the `j .` self-loop halt idiom, and traps misaligned or out-of-range next addresses. It also counts retired instructions.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IMEM_BYTES`, 1024: instruction memory size in bytes. A next address ≥ `IMEM_BYTES` is out of range.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `start`  in  1  level-sampled request to leave IDLE and begin/resume execution.
- `step_mode`  in  1  when 1, return to IDLE after each committed instruction.
- `halt_req`  in  1  external halt; takes effect after the current instruction commits.
- `next_pc_in`  in  32  next address computed by the core (its `Addr_Out`).
- `pc_out`  out  32  current PC, fed to the core's `Addr_In`; registered.
- `commit`  out  1  enables the core's register-file and data-memory writes this cycle; combinational.
- `state`  out  2  IDLE=2'b00, RUN=2'b01, HALT=2'b10, FAULT=2'b11.
- `retired`  out  32  count of committed instructions; saturates at 32'hFFFF_FFFF.
- `fault_addr`  out  32  offending `next_pc_in` captured on entry to FAULT.

## Operation
- `addr_ok` = (`next_pc_in[1:0]` == 2'b00) && (`next_pc_in` < `IMEM_BYTES`), using a 32-bit unsigned compare.
- `commit` = (`state` == RUN) && `addr_ok`. It is 0 in every other state.
- **IDLE**
  - `start`=1 → RUN.
  - Otherwise hold. `pc_out` and `retired` are unchanged.
- **RUN** (evaluated on each rising edge, in this priority order):
  1. `!addr_ok` → FAULT. `fault_addr` <= `next_pc_in`. `pc_out` and `retired` are unchanged; the instruction does not commit.
  2. Otherwise the instruction commits: `pc_out` <= `next_pc_in` and `retired` increments (saturating). The next state is then:
     - HALT if `next_pc_in` == `pc_out` (self-loop) or `halt_req`=1;
     - else IDLE if `step_mode`=1;
     - else RUN.
  - `start` is ignored while in RUN.
- **HALT**: terminal until `rst`. `commit`=0; `start`, `halt_req` and `step_mode` are ignored.
- **FAULT**: terminal until `rst`. `commit`=0; `fault_addr` holds its value.
- `rst` overrides every other input in every state:
  - `state` <= IDLE
  - `pc_out` <= `RESET_PC`
  - `retired` <= 0
  - `fault_addr` <= 0
- Reset in the middle of RUN discards the in-flight instruction. `commit` falls to 0 in the cycle after the reset edge, because `state` is then IDLE.

## Timing
- Reset values:
  - `pc_out` = `RESET_PC`
  - `state` = IDLE
  - `commit` = 0
  - `retired` = 0
  - `fault_addr` = 0
- `start` sampled high at edge k → `state`=RUN after edge k. The first instruction (at `pc_out`) commits during cycle k..k+1, and `pc_out` and `retired` update at edge k+1.
- In continuous RUN, throughput is one instruction per cycle. `pc_out` changes only on commit edges.
- In step mode, each `start` pulse retires exactly one instruction. `state` shows RUN for one cycle, then IDLE. Holding `start` high gives one commit every 2 cycles.
- `halt_req` asserted during the cycle of a commit: that instruction still commits and `state`=HALT after the edge. No further commits occur.
- Simultaneous self-loop and `step_mode`: HALT wins.
- Simultaneous `!addr_ok` and `halt_req`: FAULT wins, with no commit.
- `retired` at 32'hFFFF_FFFF stays at that value on further commits.
- `commit` depends combinationally on `next_pc_in`. The core's next-address path is therefore part of the `commit` timing path.

## Test plan
- **Reset then run:** `rst` 1 cycle, `start`=1; core model returns `next_pc_in`=`pc_out`+4 → `pc_out` = 0, 4, 8, 12 on successive edges; `retired` = 1, 2, 3; `commit`=1 every RUN cycle.
- **Self-loop halt:** at `pc_out`=0x10, `next_pc_in`=0x10 → `retired` increments once, `state`=HALT, `commit`=0; `pc_out` stays 0x10 for 10 further cycles despite `start`=1.
- **Misaligned fault:** at `pc_out`=0x8, `next_pc_in`=0x0000_000E → `commit`=0 that cycle; `state`=FAULT; `fault_addr`=0xE; `pc_out`=0x8; `retired` unchanged.
- **Range fault:** `IMEM_BYTES`=1024, `next_pc_in`=0x400 → FAULT with `fault_addr`=0x400. The value 0x3FC is accepted.
- **Step mode:** `step_mode`=1, three single-cycle `start` pulses spaced 4 cycles apart → exactly 3 commits; `retired`=3; `pc_out`=12; `state`=IDLE between pulses.
- **Priority and reset:** `halt_req`=1 together with `step_mode`=1 → HALT after one commit. Then `rst` mid-HALT → `pc_out`=`RESET_PC`, `retired`=0, `state`=IDLE. Then `start` runs again from `RESET_PC`.
